// File: rtl/cpu_sequencer.sv
// Multi-cycle MIPS control sequencer: owns the instruction state register and drives
// every datapath enable, with memory stalls, a MULT/DIV wait state and delay-slot tracking.
module cpu_sequencer #(
    parameter int unsigned MD_CYCLES       = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic [5:0] function_i,
    input  logic       waitrequest_i,
    input  logic       branch_taken_i,
    input  logic       pc_next_zero_i,
    output logic [2:0] state_o,
    output logic       active_o,
    output logic       fault_o,
    output logic       pc_wen_o,
    output logic       ir_wen_o,
    output logic       ram_wen_o,
    output logic       ram_rds_o,
    output logic       reg_wen_o,
    output logic       src_b_sel_o,
    output logic       ram_a_sel_o,
    output logic [1:0] reg_wd_sel_o,
    output logic       reg_a3_sel_o,
    output logic [1:0] pc_sel_o,
    output logic       tgt_wen_o,
    output logic       md_start_o,
    output logic       hilo_wen_o
);
    localparam int unsigned CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SW  = 6'h2B;
    localparam logic [5:0] F_JR   = 6'h08, F_MFHI  = 6'h10, F_MFLO = 6'h12, F_MULT = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B, F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23, F_AND   = 6'h24, F_OR   = 6'h25;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EXEC1  = 3'd1,
        S_EXEC2  = 3'd2,
        S_MDWAIT = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t           r_state, w_next;
    logic             r_ir_done, r_fault, r_pending;
    logic [1:0]       r_saved_sel;
    logic [CNT_W-1:0] r_md_cnt;

    logic w_is_alur, w_is_addiu, w_is_lw, w_is_sw, w_is_md, w_is_mf;
    logic w_is_br, w_is_j, w_is_jr, w_illegal;
    logic w_pc_wen, w_ir_wen, w_ram_wen, w_ram_rds, w_reg_wen, w_src_b, w_ram_a;
    logic w_reg_a3, w_tgt_wen, w_md_start, w_hilo_wen, w_set_fault, w_take;
    logic [1:0] w_reg_wd, w_pc_sel;

    // Instruction decode from the IR fields
    always_comb begin
        w_is_alur  = 1'b0;
        w_is_addiu = 1'b0;
        w_is_lw    = 1'b0;
        w_is_sw    = 1'b0;
        w_is_md    = 1'b0;
        w_is_mf    = 1'b0;
        w_is_br    = 1'b0;
        w_is_j     = 1'b0;
        w_is_jr    = 1'b0;
        w_illegal  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                case (function_i)
                    F_ADDU, F_SUBU, F_AND, F_OR:     w_is_alur = 1'b1;
                    F_MULT, F_MULTU, F_DIV, F_DIVU:  w_is_md   = 1'b1;
                    F_MFHI, F_MFLO:                  w_is_mf   = 1'b1;
                    F_JR:                            w_is_jr   = 1'b1;
                    default:                         w_illegal = 1'b1;
                endcase
            end
            OP_J:           w_is_j     = 1'b1;
            OP_BEQ, OP_BNE: w_is_br    = 1'b1;
            OP_ADDIU:       w_is_addiu = 1'b1;
            OP_LW:          w_is_lw    = 1'b1;
            OP_SW:          w_is_sw    = 1'b1;
            default:        w_illegal  = 1'b1;
        endcase
    end

    // Next state and raw strobes
    always_comb begin
        w_next      = r_state;
        w_pc_wen    = 1'b0;
        w_ir_wen    = 1'b0;
        w_ram_wen   = 1'b0;
        w_ram_rds   = 1'b0;
        w_reg_wen   = 1'b0;
        w_src_b     = 1'b0;
        w_ram_a     = 1'b0;
        w_reg_wd    = 2'b00;
        w_reg_a3    = 1'b0;
        w_pc_sel    = 2'b00;
        w_tgt_wen   = 1'b0;
        w_md_start  = 1'b0;
        w_hilo_wen  = 1'b0;
        w_set_fault = 1'b0;
        w_take      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ram_rds = 1'b1;
                if (!waitrequest_i) w_next = S_EXEC1;
            end
            S_EXEC1: begin
                w_ir_wen = !r_ir_done;
                if (w_illegal && HALT_ON_ILLEGAL) begin
                    w_set_fault = 1'b1;
                    w_next      = S_HALT;
                end else if (w_is_lw) begin
                    w_ram_rds = 1'b1;
                    w_ram_a   = 1'b1;
                    w_src_b   = 1'b1;
                    if (!waitrequest_i) w_next = S_EXEC2;
                end else if (w_is_md) begin
                    w_md_start = 1'b1;
                    w_next     = S_MDWAIT;
                end else begin
                    w_next = S_EXEC2;
                end
            end
            S_MDWAIT: begin
                if (r_md_cnt == '0) begin
                    w_hilo_wen = 1'b1;
                    w_next     = S_EXEC2;
                end
            end
            S_EXEC2: begin
                w_pc_wen = !(w_is_sw && waitrequest_i);
                if (w_is_addiu) begin
                    w_reg_wen = 1'b1;
                    w_src_b   = 1'b1;
                    w_reg_wd  = 2'b01;
                end else if (w_is_alur) begin
                    w_reg_wen = 1'b1;
                    w_reg_wd  = 2'b01;
                    w_reg_a3  = 1'b1;
                end else if (w_is_lw) begin
                    w_reg_wen = 1'b1;
                end else if (w_is_mf) begin
                    w_reg_wen = 1'b1;
                    w_reg_wd  = 2'b10;
                    w_reg_a3  = 1'b1;
                end else if (w_is_sw) begin
                    w_ram_wen = 1'b1;
                    w_ram_a   = 1'b1;
                    w_src_b   = 1'b1;
                end
                // A taken transfer latches its target; the slot instruction then steers the PC
                w_take = w_is_j || w_is_jr || (w_is_br && branch_taken_i);
                if (w_take)         w_tgt_wen = 1'b1;
                else if (r_pending) w_pc_sel  = r_saved_sel;
                if (w_pc_wen) w_next = pc_next_zero_i ? S_HALT : S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_ir_done   <= 1'b0;
            r_fault     <= 1'b0;
            r_pending   <= 1'b0;
            r_saved_sel <= 2'b00;
            r_md_cnt    <= '0;
        end else begin
            r_state   <= w_next;
            r_ir_done <= (r_state == S_EXEC1) && (w_next == S_EXEC1);
            if (w_set_fault) r_fault <= 1'b1;
            if (w_md_start)
                r_md_cnt <= CNT_W'(MD_CYCLES - 1);
            else if (r_state == S_MDWAIT && r_md_cnt != '0)
                r_md_cnt <= r_md_cnt - CNT_W'(1);
            if (r_state == S_EXEC2 && w_pc_wen) begin
                r_pending <= w_take;
                if (w_take) r_saved_sel <= w_is_jr ? 2'b10 : 2'b01;
            end
        end
    end

    // Strobes are forced low while reset is held
    assign state_o      = r_state;
    assign active_o     = (r_state != S_HALT) && !reset;
    assign fault_o      = r_fault;
    assign pc_wen_o     = w_pc_wen   && !reset;
    assign ir_wen_o     = w_ir_wen   && !reset;
    assign ram_wen_o    = w_ram_wen  && !reset;
    assign ram_rds_o    = w_ram_rds  && !reset;
    assign reg_wen_o    = w_reg_wen  && !reset;
    assign tgt_wen_o    = w_tgt_wen  && !reset;
    assign md_start_o   = w_md_start && !reset;
    assign hilo_wen_o   = w_hilo_wen && !reset;
    assign src_b_sel_o  = w_src_b;
    assign ram_a_sel_o  = w_ram_a;
    assign reg_wd_sel_o = w_reg_wd;
    assign reg_a3_sel_o = w_reg_a3;
    assign pc_sel_o     = w_pc_sel;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: per-instruction cycle scripts built from the ISA timing rules,
// with randomized waits, don't-care inputs and instruction mix.
module tb_cpu_sequencer;
    localparam int MD = 4;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam int C_ALUR = 0, C_ADDIU = 1, C_LW = 2, C_SW = 3, C_MD = 4;
    localparam int C_MF = 5, C_BR = 6, C_J = 7, C_JR = 8, C_ILL = 9;

    typedef struct packed {
        logic [2:0] st;
        logic act, flt, pcw, irw, rmw, rds, rgw, srcb, rama;
        logic [1:0] wd;
        logic a3;
        logic [1:0] pcs;
        logic tgw, mds, hlw;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0;
    logic [5:0] opcode = '0, func = '0;
    logic waitreq = 1'b0, btaken = 1'b0, pczero = 1'b0;
    logic [2:0] state_o;
    logic active_o, fault_o, pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o, reg_wen_o;
    logic src_b_sel_o, ram_a_sel_o, reg_a3_sel_o, tgt_wen_o, md_start_o, hilo_wen_o;
    logic [1:0] reg_wd_sel_o, pc_sel_o;

    int n_vec = 0, n_err = 0;
    logic m_pending = 1'b0, m_fault = 1'b0, m_halted = 1'b0;
    logic [1:0] m_saved = 2'b00;

    cpu_sequencer #(.MD_CYCLES(MD), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode), .function_i(func),
        .waitrequest_i(waitreq), .branch_taken_i(btaken), .pc_next_zero_i(pczero),
        .state_o(state_o), .active_o(active_o), .fault_o(fault_o), .pc_wen_o(pc_wen_o),
        .ir_wen_o(ir_wen_o), .ram_wen_o(ram_wen_o), .ram_rds_o(ram_rds_o),
        .reg_wen_o(reg_wen_o), .src_b_sel_o(src_b_sel_o), .ram_a_sel_o(ram_a_sel_o),
        .reg_wd_sel_o(reg_wd_sel_o), .reg_a3_sel_o(reg_a3_sel_o), .pc_sel_o(pc_sel_o),
        .tgt_wen_o(tgt_wen_o), .md_start_o(md_start_o), .hilo_wen_o(hilo_wen_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
        $fatal(1);
    end

    function automatic vec_t observed();
        vec_t o;
        o.st = state_o;    o.act = active_o;   o.flt = fault_o;     o.pcw = pc_wen_o;
        o.irw = ir_wen_o;  o.rmw = ram_wen_o;  o.rds = ram_rds_o;   o.rgw = reg_wen_o;
        o.srcb = src_b_sel_o; o.rama = ram_a_sel_o; o.wd = reg_wd_sel_o; o.a3 = reg_a3_sel_o;
        o.pcs = pc_sel_o;  o.tgw = tgt_wen_o;  o.mds = md_start_o;  o.hlw = hilo_wen_o;
        return o;
    endfunction

    function automatic vec_t base(input logic [2:0] st);
        vec_t v = '0;
        v.st  = st;
        v.act = (st != 3'd4);
        v.flt = m_fault;
        return v;
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R: case (fn)
                6'h21, 6'h23, 6'h24, 6'h25: return C_ALUR;
                6'h18, 6'h19, 6'h1A, 6'h1B: return C_MD;
                6'h10, 6'h12:               return C_MF;
                6'h08:                      return C_JR;
                default:                    return C_ILL;
            endcase
            OP_J:           return C_J;
            OP_BEQ, OP_BNE: return C_BR;
            OP_ADDIU:       return C_ADDIU;
            OP_LW:          return C_LW;
            OP_SW:          return C_SW;
            default:        return C_ILL;
        endcase
    endfunction

    task automatic check(input string tag, input vec_t o, input vec_t e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock: drive inputs at the falling edge, compare once they settle
    task automatic step(input string tag, input vec_t e, input logic [5:0] op,
                        input logic [5:0] fn, input logic wr, input logic bt, input logic pz);
        @(negedge clk);
        opcode = op; func = fn; waitreq = wr; btaken = bt; pczero = pz;
        #1;
        check(tag, observed(), e);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        check("reset.async", observed(), vec_t'(0));
        @(posedge clk);
        #1;
        check("reset.hold", observed(), vec_t'(0));
        reset = 1'b0;
        m_pending = 1'b0; m_fault = 1'b0; m_halted = 1'b0; m_saved = 2'b00;
    endtask

    task automatic halt_cycles(input string nm, input int n);
        for (int i = 0; i < n; i++)
            step($sformatf("%s.halt%0d", nm, i), base(3'd4), 6'($urandom), 6'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Expected cycle script for one instruction, derived from its class and wait counts
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int ew, input int sw, input logic taken,
                             input logic pz, input int md_abort);
        int c, n2;
        logic jumpy, last;
        vec_t e;
        c = classify(op, fn);
        for (int i = 0; i <= fw; i++) begin
            e = base(3'd0); e.rds = 1'b1;
            step($sformatf("%s.fetch%0d", nm, i), e, 6'($urandom), 6'($urandom),
                 (i < fw), 1'($urandom), 1'($urandom));
        end
        if (c == C_LW) begin
            for (int i = 0; i <= ew; i++) begin
                e = base(3'd1); e.irw = (i == 0); e.rds = 1'b1; e.rama = 1'b1; e.srcb = 1'b1;
                step($sformatf("%s.exec1_%0d", nm, i), e, op, fn, (i < ew),
                     1'($urandom), 1'($urandom));
            end
        end else begin
            e = base(3'd1); e.irw = 1'b1; e.mds = (c == C_MD);
            step($sformatf("%s.exec1", nm), e, op, fn, 1'($urandom), 1'($urandom), 1'($urandom));
            if (c == C_ILL) begin
                m_fault = 1'b1; m_halted = 1'b1;
                return;
            end
        end
        if (c == C_MD) begin
            for (int i = 0; i < MD; i++) begin
                if (i == md_abort) return;
                e = base(3'd3); e.hlw = (i == MD - 1);
                step($sformatf("%s.mdwait%0d", nm, i), e, op, fn, 1'($urandom),
                     1'($urandom), 1'($urandom));
            end
        end
        jumpy = (c == C_J) || (c == C_JR) || (c == C_BR && taken);
        n2 = (c == C_SW) ? sw + 1 : 1;
        for (int i = 0; i < n2; i++) begin
            last = (i == n2 - 1);
            e = base(3'd2); e.pcw = last;
            case (c)
                C_ADDIU: begin e.rgw = 1'b1; e.srcb = 1'b1; e.wd = 2'b01; end
                C_ALUR:  begin e.rgw = 1'b1; e.wd = 2'b01; e.a3 = 1'b1; end
                C_LW:    begin e.rgw = 1'b1; end
                C_MF:    begin e.rgw = 1'b1; e.wd = 2'b10; e.a3 = 1'b1; end
                C_SW:    begin e.rmw = 1'b1; e.rama = 1'b1; e.srcb = 1'b1; end
                default: ;
            endcase
            if (jumpy)          e.tgw = 1'b1;
            else if (m_pending) e.pcs = m_saved;
            step($sformatf("%s.exec2_%0d", nm, i), e, op, fn,
                 (c == C_SW) ? !last : 1'($urandom),
                 (c == C_BR) ? taken : 1'($urandom),
                 last ? pz : 1'($urandom));
        end
        if (jumpy) begin
            m_pending = 1'b1;
            m_saved   = (c == C_JR) ? 2'd2 : 2'd1;
        end else begin
            m_pending = 1'b0;
        end
        if (pz) m_halted = 1'b1;
    endtask

    logic [11:0] ilist [17];
    string       inames [17];

    initial begin
        ilist = '{ {OP_R, 6'h21}, {OP_R, 6'h23}, {OP_R, 6'h24}, {OP_R, 6'h25},
                   {OP_ADDIU, 6'h00}, {OP_LW, 6'h00}, {OP_SW, 6'h00},
                   {OP_R, 6'h18}, {OP_R, 6'h19}, {OP_R, 6'h1A}, {OP_R, 6'h1B},
                   {OP_R, 6'h10}, {OP_R, 6'h12},
                   {OP_BEQ, 6'h00}, {OP_BNE, 6'h00}, {OP_J, 6'h00}, {OP_R, 6'h08} };
        inames = '{ "addu", "subu", "and", "or", "addiu", "lw", "sw", "mult", "multu",
                    "div", "divu", "mfhi", "mflo", "beq", "bne", "j", "jr" };
        #2;
        async_reset();

        run_instr("addu",  OP_R,   6'h21, 0, 0, 0, 1'b0, 1'b0, -1);
        run_instr("lw",    OP_LW,  6'h11, 2, 3, 0, 1'b0, 1'b0, -1);
        run_instr("sw",    OP_SW,  6'h05, 0, 0, 2, 1'b0, 1'b0, -1);
        run_instr("mult",  OP_R,   6'h18, 1, 0, 0, 1'b0, 1'b0, -1);
        run_instr("beq_t", OP_BEQ, 6'h00, 0, 0, 0, 1'b1, 1'b0, -1);
        run_instr("slot1", OP_ADDIU, 6'h3F, 0, 0, 0, 1'b0, 1'b0, -1);
        run_instr("after1", OP_R,  6'h21, 0, 0, 0, 1'b0, 1'b0, -1);
        run_instr("j",     OP_J,   6'h2A, 1, 0, 0, 1'b0, 1'b0, -1);
        run_instr("slot2", OP_LW,  6'h00, 1, 2, 0, 1'b0, 1'b0, -1);
        run_instr("jr",    OP_R,   6'h08, 0, 0, 0, 1'b0, 1'b0, -1);
        run_instr("slot3", OP_SW,  6'h00, 0, 0, 3, 1'b0, 1'b0, -1);
        run_instr("bne_nt", OP_BNE, 6'h00, 0, 0, 0, 1'b0, 1'b0, -1);
        run_instr("after4", OP_R,  6'h12, 0, 0, 0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 120; n++) begin
            int k;
            logic [5:0] op, fn;
            k  = m_pending ? int'($urandom_range(12, 0)) : int'($urandom_range(16, 0));
            op = ilist[k][11:6];
            fn = (op == OP_R) ? ilist[k][5:0] : 6'($urandom);
            run_instr(inames[k], op, fn, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                      int'($urandom_range(3, 0)), 1'($urandom), 1'b0, -1);
        end

        run_instr("mult_abort", OP_R, 6'h1A, 0, 0, 0, 1'b0, 1'b0, 2);
        async_reset();
        run_instr("multu", OP_R, 6'h19, 0, 0, 0, 1'b0, 1'b0, -1);

        run_instr("beq_rst", OP_BEQ, 6'h00, 0, 0, 0, 1'b1, 1'b0, -1);
        async_reset();
        run_instr("post_rst", OP_R, 6'h25, 0, 0, 0, 1'b0, 1'b0, -1);

        run_instr("jr0",  OP_R, 6'h08, 0, 0, 0, 1'b0, 1'b0, -1);
        run_instr("slot0", OP_R, 6'h21, 0, 0, 0, 1'b0, 1'b1, -1);
        halt_cycles("jr0", 5);
        async_reset();

        run_instr("illegal", 6'h3F, 6'h00, 1, 0, 0, 1'b0, 1'b0, -1);
        halt_cycles("illegal", 4);
        async_reset();
        run_instr("ill_func", OP_R, 6'h01, 0, 0, 0, 1'b0, 1'b0, -1);
        halt_cycles("ill_func", 2);
        async_reset();
        run_instr("final", OP_ADDIU, 6'h00, 0, 0, 0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
